// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Optional build macro used by this block: IMEM_ARB_RR_EN (round-robin grant).
package imem_arb_pkg;

   localparam int IMEM_ADDR_W   = 10;
   localparam int IMEM_DATA_W   = 32;
   localparam int IMEM_TURN_CYC = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      RDATA = 3'd3,
      TURN  = 3'd4
   } arb_state_t;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_LOAD  = 1'b1
   } gnt_src_t;

   // Width of a down-counter that must hold values 0..n-1 (at least 1 bit).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational grant selector for the loader/fetch pair.
// IMEM_ARB_RR_EN selects round-robin with a last-grant register; otherwise the loader wins.
module imem_arb_pick
   import imem_arb_pkg::*;
(
`ifdef IMEM_ARB_RR_EN
   input  logic i_clk,
`endif
   input  logic i_rst,
   input  logic i_idle,
   input  logic i_if_req,
   input  logic i_ld_req,
   output logic o_if_gnt,
   output logic o_ld_gnt
);

   logic w_open;
   logic w_ld_wins;

   assign w_open = i_idle & ~i_rst;

`ifdef IMEM_ARB_RR_EN
   gnt_src_t r_last;

   // On a tie the requester that was not served last goes first.
   always_comb begin
      w_ld_wins = i_ld_req & (~i_if_req | (r_last == GNT_FETCH));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= GNT_FETCH;
      end else if (o_ld_gnt) begin
         r_last <= GNT_LOAD;
      end else if (o_if_gnt) begin
         r_last <= GNT_FETCH;
      end
   end
`else
   assign w_ld_wins = i_ld_req;
`endif

   assign o_ld_gnt = w_open & w_ld_wins;
   assign o_if_gnt = w_open & i_if_req & ~w_ld_wins;

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory sequencer: loader writes, fetch reads, owns the data bus.
// Build macro IMEM_ARB_RR_EN switches the selector to round-robin arbitration.
//
// state | meaning
// IDLE  | bus released, grants open
// WRITE | address/we/data presented, arbiter drives mem_data
// READ  | read address presented, bus released
// RDATA | memory drives mem_data, captured into if_rdata
// TURN  | turnaround after memory drive, if_rvalid pulses on entry
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W   = IMEM_ADDR_W,
   parameter int DATA_W   = IMEM_DATA_W,
   parameter int TURN_CYC = IMEM_TURN_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic              busy
);

   localparam int TC_W = cnt_width(TURN_CYC);
   localparam logic [TC_W-1:0] TC_LOAD = (TURN_CYC > 0) ? TC_W'(TURN_CYC - 1) : '0;

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic              r_busy;
   logic [TC_W-1:0]   r_turn_cnt;
   logic              w_if_gnt;
   logic              w_ld_gnt;
   logic              w_ld_acc;
   logic              w_if_acc;

   imem_arb_pick u_pick (
`ifdef IMEM_ARB_RR_EN
      .i_clk    (clk),
`endif
      .i_rst    (rst),
      .i_idle   (r_state == IDLE),
      .i_if_req (if_req),
      .i_ld_req (ld_req),
      .o_if_gnt (w_if_gnt),
      .o_ld_gnt (w_ld_gnt)
   );

   assign w_ld_acc = ld_req & w_ld_gnt;
   assign w_if_acc = if_req & w_if_gnt;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_ld_acc) begin
               w_next = WRITE;
            end else if (w_if_acc) begin
               w_next = READ;
            end
         end
         WRITE:   w_next = IDLE;
         READ:    w_next = RDATA;
         RDATA:   w_next = (TURN_CYC == 0) ? IDLE : TURN;
         TURN:    w_next = (r_turn_cnt == '0) ? IDLE : TURN;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_mem_addr <= '0;
         r_mem_we   <= 1'b0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
         r_busy     <= 1'b0;
         r_turn_cnt <= '0;
      end else begin
         r_state  <= w_next;
         r_busy   <= (w_next != IDLE);
         r_mem_we <= (w_next == WRITE);
         r_rvalid <= (r_state == RDATA);

         if (w_ld_acc) begin
            r_mem_addr <= ld_addr;
            r_wdata    <= ld_data;
         end else if (w_if_acc) begin
            r_mem_addr <= if_addr;
         end

         if (r_state == RDATA) begin
            r_rdata <= mem_data;
         end

         // Turnaround timer: loaded on leaving RDATA, counts down to terminal zero.
         if (r_state == RDATA) begin
            r_turn_cnt <= TC_LOAD;
         end else if ((r_state == TURN) && (r_turn_cnt != '0)) begin
            r_turn_cnt <= r_turn_cnt - 1'b1;
         end
      end
   end

   assign mem_data  = (r_state == WRITE) ? r_wdata : {DATA_W{1'bz}};
   assign mem_addr  = r_mem_addr;
   assign mem_we    = r_mem_we;
   assign if_rdata  = r_rdata;
   assign if_rvalid = r_rvalid;
   assign if_gnt    = w_if_gnt;
   assign ld_gnt    = w_ld_gnt;
   assign busy      = r_busy;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: memory model, read scoreboard, vector table and corner sequences.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [9:0]  if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ld_req;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ld_gnt;
   logic [9:0]  mem_addr;
   logic        mem_we;
   wire  [31:0] mem_data;
   logic        busy;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      bit          wr;
      logic [9:0]  addr;
      logic [31:0] data;
   } vec_t;

   vec_t        vt [16];
   logic [31:0] sb [$];
   logic [31:0] rd_log [$];
   logic [31:0] ref_mem [0:1023];
   logic [31:0] tb_mem  [0:1023];
   logic        rd_pend = 1'b0;
   logic        rd_slot = 1'b0;
   logic [31:0] rd_q = 32'h0;
   logic        model_last = 1'b0;

   always #5 clk = ~clk;

   imem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .ld_req    (ld_req),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_gnt    (ld_gnt),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_data  (mem_data),
      .busy      (busy)
   );

   // Memory: writes on the edge, read data driven in the cycle after the address cycle.
   // When neither side should drive, the bench holds the bus at zero so a stray DUT driver shows up.
   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_addr] <= mem_data;
      rd_slot <= !rst && rd_pend;
      rd_q    <= tb_mem[mem_addr];
      rd_pend <= !rst && if_req && if_gnt;
   end

   assign mem_data = mem_we ? {32{1'bz}} : (rd_slot ? rd_q : 32'h0);

   always @(posedge clk) begin
      if (rst) model_last <= 1'b0;
      else if (ld_req && ld_gnt) model_last <= 1'b1;
      else if (if_req && if_gnt) model_last <= 1'b0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      chk(nm, 32'(act), 32'(exp));
   endtask

   function automatic logic exp_ld_wins();
`ifdef IMEM_ARB_RR_EN
      return !model_last;
`else
      return 1'b1;
`endif
   endfunction

   always @(negedge clk) begin
      if (if_rvalid) begin
         if (sb.size() == 0) begin
            chkb("rvalid_spurious", if_rvalid, 1'b0);
         end else begin
            rd_log.push_back(if_rdata);
            chk("sb_rdata", if_rdata, sb.pop_front());
         end
      end
      if (!rst && if_req && if_gnt) begin
         chk("read_done_before_gnt", 32'(sb.size()), 32'd0);
         sb.push_back(ref_mem[if_addr]);
      end
      if (!rst && ld_req && ld_gnt) ref_mem[ld_addr] <= ld_data;
      if (!mem_we && !rd_slot) chk("bus_released", mem_data, 32'h0);
      chkb("gnt_exclusive", if_gnt & ld_gnt, 1'b0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb.size() != 0; k++) step();
      step();
      step();
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic issue(input vec_t v);
      bit got = 1'b0;
      if (v.wr) begin
         ld_req = 1'b1; ld_addr = v.addr; ld_data = v.data;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (v.wr ? ld_gnt : if_gnt) begin
            got = 1'b1;
            break;
         end
         step();
      end
      chkb(v.wr ? "wr_gnt_seen" : "rd_gnt_seen", got, 1'b1);
      step();
      ld_req  = 1'b0;
      if_req  = 1'b0;
      ld_addr = 10'($urandom);
      ld_data = $urandom;
      if_addr = 10'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      for (int i = 0; i < 8; i++) begin
         vt[i]     = '{1'b1, 10'(i), 32'(i)};
         vt[8 + i] = '{1'b0, 10'(i), 32'(i)};
      end

      // Reset: requests held high must not be granted.
      rst = 1'b1; if_req = 1'b1; ld_req = 1'b1;
      if_addr = 10'h005; ld_addr = 10'h005; ld_data = 32'h0;
      step();
      @(negedge clk);
      chkb("rst_ld_gnt", ld_gnt, 1'b0);
      chkb("rst_if_gnt", if_gnt, 1'b0);
      chkb("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_rvalid", if_rvalid, 1'b0);
      chk("rst_rdata", if_rdata, 32'h0);
      step();
      rst = 1'b0; if_req = 1'b0;
      ld_req = 1'b1; ld_addr = 10'h005; ld_data = 32'hDEADBEEF;

      // Write 0x005 <- DEADBEEF
      @(negedge clk);
      chkb("wr_gnt", ld_gnt, 1'b1);
      step();
      ld_req = 1'b0; ld_addr = 10'h3FF; ld_data = 32'h0;
      @(negedge clk);
      chkb("wr_we", mem_we, 1'b1);
      chk("wr_addr", 32'(mem_addr), 32'h005);
      chk("wr_bus", mem_data, 32'hDEADBEEF);
      chkb("wr_busy", busy, 1'b1);
      step();
      @(negedge clk);
      chkb("wr_done_we", mem_we, 1'b0);
      chkb("wr_done_busy", busy, 1'b0);
      chk("wr_addr_hold", 32'(mem_addr), 32'h005);

      // Read 0x005
      step();
      if_req = 1'b1; if_addr = 10'h005;
      @(negedge clk);
      chkb("rd_gnt", if_gnt, 1'b1);
      step();
      if_req = 1'b0; if_addr = 10'h3FF;
      @(negedge clk);
      chkb("rd_we", mem_we, 1'b0);
      chk("rd_addr", 32'(mem_addr), 32'h005);
      chkb("rd_busy", busy, 1'b1);
      step();
      @(negedge clk);
      chkb("rdata_cyc_rvalid", if_rvalid, 1'b0);
      chk("rdata_cyc_bus", mem_data, 32'hDEADBEEF);
      step();
      @(negedge clk);
      chkb("rvalid_n3", if_rvalid, 1'b1);
      chk("rdata_n3", if_rdata, 32'hDEADBEEF);
      step();
      @(negedge clk);
      chkb("rvalid_one_pulse", if_rvalid, 1'b0);
      chkb("rd_idle_busy", busy, 1'b0);
      chk("rdata_hold", if_rdata, 32'hDEADBEEF);

      // Contention
      step();
      ld_req = 1'b1; ld_addr = 10'h010; ld_data = 32'h12345678;
      if_req = 1'b1; if_addr = 10'h005;
      @(negedge clk);
      chkb("cont_ld_gnt", ld_gnt, exp_ld_wins());
      chkb("cont_if_gnt", if_gnt, !exp_ld_wins());
      step();
      ld_req = 1'b0;
      @(negedge clk);
      chkb("cont_fetch_waits", if_gnt, 1'b0);
      step();
      @(negedge clk);
      chkb("cont_fetch_next", if_gnt, 1'b1);
      step();
      if_req = 1'b0;
      drain();

      // Constant dual request
      ld_req = 1'b1; ld_addr = 10'h020; ld_data = 32'hAAAA5555;
      if_req = 1'b1; if_addr = 10'h010;
      for (int g = 0; g < 4; g++) begin
         got = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if_gnt || ld_gnt) begin
               got = 1'b1;
               break;
            end
            step();
         end
         chkb("dual_gnt_seen", got, 1'b1);
         chkb("dual_pick", ld_gnt, exp_ld_wins());
         step();
      end
      ld_req = 1'b0; if_req = 1'b0;
      drain();

      // Fill loop from the vector table
      rd_log.delete();
      for (int i = 0; i < 16; i++) issue(vt[i]);
      drain();
      chk("fill_rd_count", 32'(rd_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < rd_log.size(); i++) chk("fill_rdata", rd_log[i], vt[8 + i].data);

      // Turnaround: read 0x000 with a write to 0x001 pending
      step();
      if_req = 1'b1; if_addr = 10'h000;
      @(negedge clk);
      chkb("ta_rd_gnt", if_gnt, 1'b1);
      step();
      if_req = 1'b0; ld_req = 1'b1; ld_addr = 10'h001; ld_data = 32'hCAFEF00D;
      @(negedge clk);
      chkb("ta_read_no_gnt", ld_gnt, 1'b0);
      step();
      @(negedge clk);
      chkb("ta_rdata_no_gnt", ld_gnt, 1'b0);
      chkb("ta_rdata_we", mem_we, 1'b0);
      step();
      @(negedge clk);
      chkb("ta_turn_no_gnt", ld_gnt, 1'b0);
      chkb("ta_turn_we", mem_we, 1'b0);
      chkb("ta_turn_rvalid", if_rvalid, 1'b1);
      step();
      @(negedge clk);
      chkb("ta_idle_gnt", ld_gnt, 1'b1);
      chkb("ta_idle_busy", busy, 1'b0);
      step();
      ld_req = 1'b0;
      @(negedge clk);
      chkb("ta_wr_we", mem_we, 1'b1);
      chk("ta_wr_addr", 32'(mem_addr), 32'h001);
      chk("ta_wr_bus", mem_data, 32'hCAFEF00D);
      step();

      // Give if_rdata a nonzero value, then reset in the middle of a read
      issue('{1'b0, 10'h007, 32'h0});
      drain();
      chk("pre_rst_rdata", if_rdata, 32'h7);
      step();
      if_req = 1'b1; if_addr = 10'h003;
      @(negedge clk);
      chkb("mr_gnt", if_gnt, 1'b1);
      step();
      if_req = 1'b0; rst = 1'b1;
      @(negedge clk);
      chkb("mr_read_busy", busy, 1'b1);
      step();
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chkb("mr_busy", busy, 1'b0);
      chkb("mr_we", mem_we, 1'b0);
      chkb("mr_rvalid", if_rvalid, 1'b0);
      chk("mr_rdata", if_rdata, 32'h0);
      chk("mr_addr", 32'(mem_addr), 32'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         @(negedge clk);
         chkb("mr_no_rvalid", if_rvalid, 1'b0);
      end

      chk("sb_final", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Sequences all accesses to the 1K x 32 instruction memory and shares its single port between two requesters:
  - fetch unit: reads;
  - program loader: boot-time and debug writes.
- Drives memory address and write-enable.
- Owns the bidirectional memory data bus: drives it on writes, releases it on reads, and inserts bus turnaround.
- Sits between the fetch stage/loader and the instruction memory.

Parameters:
ADDR_W, 10, word address width
DATA_W, 32, instruction word width
TURN_CYC, 1, idle cycles inserted after a memory-driven read data cycle before the arbiter may drive the bus

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch read request
if_addr  input  ADDR_W  fetch word address
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  DATA_W  read instruction word
ld_req  input  1  loader write request
ld_addr  input  ADDR_W  loader word address
ld_data  input  DATA_W  loader write data
ld_gnt  output  1  loader request accepted this cycle
mem_addr  output  ADDR_W  memory address
mem_we  output  1  memory write enable (1 = write, 0 = read)
mem_data  inout  DATA_W  shared memory data bus
busy  output  1  state != IDLE

Behaviour:
- Memory timing (decided):
  - Memory samples mem_addr/mem_we/mem_data on the rising edge.
  - On a read, memory drives mem_data during the cycle following the address cycle.
- Clock and reset:
  - Single clock domain; all state is registered on clk.
- Reset (rst=1 at edge):
  - state=IDLE, mem_addr=0, mem_we=0, mem_data released (all Z), if_gnt=ld_gnt=0, if_rvalid=0, if_rdata=0, busy=0.
  - Any in-flight transaction is dropped: no rvalid, no write.
- FSM states: IDLE, WRITE, READ, RDATA, TURN.
- Grants:
  - if_gnt and ld_gnt are combinational and asserted only in IDLE with rst=0.
  - A transaction is accepted on the edge where req&gnt=1.
  - Requester must hold addr/data stable in the accept cycle only.
  - Only one outstanding transaction at a time.
- Arbitration: ld_req has fixed priority over if_req. Simultaneous requests grant ld and leave fetch waiting. Fetch starvation under continuous loading is accepted.
- Write path (cycle N accept):
  - N+1 WRITE: mem_addr=ld_addr, mem_we=1, mem_data driven with ld_data.
  - N+2 IDLE, bus released.
  - Back-to-back writes sustain 1 write per 2 cycles.
- Read path (cycle N accept):
  - N+1 READ: mem_addr=if_addr, mem_we=0, bus released.
  - N+2 RDATA: memory drives mem_data; arbiter registers it into if_rdata.
  - N+3: if_rvalid=1 for exactly one cycle; state = TURN for TURN_CYC cycles, then IDLE.
  - With TURN_CYC=0: RDATA goes directly to IDLE.
- Bus rules:
  - mem_data is driven by the arbiter only in WRITE.
  - The arbiter never drives in the cycle immediately after RDATA when TURN_CYC≥1.
- Hold behaviour:
  - mem_addr holds its last value outside WRITE/READ.
  - mem_we=0 in every state except WRITE.
  - if_rdata holds until the next read completes.
- Request dropped before grant: no effect. Requests arriving while busy wait; nothing is queued.
- busy tracks state != IDLE, registered.

Optional Feature:
- Macro IMEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration replaces fixed priority. A 1-bit last-grant register (reset to "fetch") selects the requester not served last when both request.
  - A single requester is always granted.
- Undefined: fixed loader priority as above.

Decomposition:
- Package imem_arb_pkg holds:
  - state encoding constants: IDLE=0, WRITE=1, READ=2, RDATA=3, TURN=4 (3-bit);
  - default ADDR_W, DATA_W, TURN_CYC.
- Sub-module imem_arb_pick: the combinational grant selector, with optional round-robin last-grant register, taking both reqs and idle and returning both gnts.
- FSM, turnaround counter and bus driver stay in imem_arbiter.

Test Plan:
- Reset/write: rst held 2 cycles, then ld_req with addr 0x005, data 0xDEADBEEF -> ld_gnt in same cycle; next cycle mem_we=1, mem_addr=0x005, mem_data=0xDEADBEEF; following cycle mem_we=0, bus Z.
- Read: after above, if_req addr 0x005 -> if_gnt; READ cycle mem_we=0, bus Z; if_rvalid pulses 3 cycles after accept with if_rdata=0xDEADBEEF.
- Contention: ld_req and if_req both high in IDLE -> ld_gnt=1, if_gnt=0. Fetch is granted on the first IDLE cycle with ld_req low. With IMEM_ARB_RR_EN, grants alternate fetch, ld, fetch... under constant dual request.
- Turnaround: read of 0x000 immediately followed by pending write to 0x001 -> exactly TURN_CYC=1 idle cycle with bus Z between RDATA and WRITE; bus checker sees no driver overlap.
- Fill loop: loader writes words 0..7 with data=address, then fetch reads 0..7 -> if_rdata equals 0..7 in order. Each read must complete with exactly one if_rvalid before the next if_gnt.
- Reset mid-read: rst asserted in READ -> next cycle IDLE, if_rvalid never pulses, if_rdata=0, bus Z.
